// File: rtl/ring_johnson_pkg.sv
// Shared types, sequence tables and decode helpers for the ring/Johnson monitor.
package ring_johnson_pkg;

    localparam int unsigned SEQ_W      = 4;
    localparam int unsigned RING_IDX_W = 2;
    localparam int unsigned JOHN_IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_SKIP    = 2'b10;
    localparam logic [1:0] ERR_STALL   = 2'b11;

    // Left-shifting sequences, index 0 in the least significant nibble.
    localparam logic [15:0] RING_TBL = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    localparam logic [31:0] JOHN_TBL = {4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                        4'b0111, 4'b0011, 4'b0001, 4'b0000};

    function automatic logic [SEQ_W-1:0] mirror4(input logic [SEQ_W-1:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic int unsigned seq_len(input bit mode);
        return mode ? 32'd8 : 32'd4;
    endfunction

    function automatic logic [SEQ_W-1:0] seq_code(input bit mode, input bit shift_left,
                                                  input logic [2:0] idx);
        logic [SEQ_W-1:0] c;
        if (mode) c = JOHN_TBL[{idx, 2'b00} +: 4];
        else      c = RING_TBL[{idx[1:0], 2'b00} +: 4];
        return shift_left ? c : mirror4(c);
    endfunction

    function automatic logic seq_is_legal(input bit mode, input bit shift_left,
                                          input logic [SEQ_W-1:0] v);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < seq_len(mode) && seq_code(mode, shift_left, 3'(i)) == v) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [2:0] seq_index(input bit mode, input bit shift_left,
                                             input logic [SEQ_W-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < seq_len(mode) && seq_code(mode, shift_left, 3'(i)) == v) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] seq_next(input bit mode, input logic [2:0] idx);
        return mode ? idx + 3'd1 : {1'b0, idx[1:0] + 2'd1};
    endfunction

endpackage

// File: rtl/ring_johnson_monitor_seq_track.sv
// Single-channel sequence tracker: decodes, classifies each step against the
// previous sample and runs the IDLE/ACQUIRE/LOCKED/FAULT lock FSM.
module seq_track
    import ring_johnson_pkg::*;
#(
    parameter bit          MODE       = 1'b0,
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned WRAP_W     = 8,
    parameter int unsigned HOLD_MAX   = 0,
    parameter bit          SHIFT_LEFT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [WIDTH-1:0]  q_i,
    input  logic              err_clr_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              locked_o,
    output logic              fault_o,
    output logic [1:0]        err_o,
    output logic [WRAP_W-1:0] wraps_o
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned HOLD_W   = 8;
    localparam logic [2:0]  LAST_IDX = MODE ? 3'd7 : 3'd3;

    state_e              state_q, state_d;
    logic [SEQ_W-1:0]    prev_q, prev_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    adv_cnt_q, adv_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [1:0]          err_q, err_d;
    logic [WRAP_W-1:0]   wraps_q, wraps_d;
    logic                locked_q, locked_d;
    logic                fault_q, fault_d;

    logic [SEQ_W-1:0]    sample_c;
    logic                legal_c, cleared_c, prev_legal_c;
    logic                hold_c, adv_c, restart_c, wrap_c, count_wrap_c;
    logic [2:0]          cur_idx_c, prev_idx_c;
    logic [HOLD_W-1:0]   hold_inc_c;

    // Step classification of the live sample against the last enabled sample.
    assign sample_c     = SEQ_W'(q_i);
    assign legal_c      = seq_is_legal(MODE, SHIFT_LEFT, sample_c);
    assign cleared_c    = !MODE && (sample_c == '0);
    assign prev_legal_c = seq_is_legal(MODE, SHIFT_LEFT, prev_q);
    assign cur_idx_c    = seq_index(MODE, SHIFT_LEFT, sample_c);
    assign prev_idx_c   = seq_index(MODE, SHIFT_LEFT, prev_q);
    assign hold_c       = (sample_c == prev_q);
    assign adv_c        = !hold_c && prev_legal_c && (cur_idx_c == seq_next(MODE, prev_idx_c));
    assign restart_c    = !hold_c && !adv_c && (cur_idx_c == 3'd0);
    assign wrap_c       = adv_c && (prev_idx_c == LAST_IDX);
    assign hold_inc_c   = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        idx_d        = idx_q;
        adv_cnt_d    = adv_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        err_d        = err_q;
        wraps_d      = wraps_q;
        count_wrap_c = 1'b0;

        if (en_i) begin
            prev_d = sample_c;
            if (legal_c)        idx_d = IDX_W'(cur_idx_c);
            else if (cleared_c) idx_d = '0;

            if (err_clr_i && state_q == ST_FAULT) begin
                state_d    = ST_IDLE;
                err_d      = ERR_NONE;
                adv_cnt_d  = '0;
                hold_cnt_d = '0;
            end else if (state_q != ST_FAULT) begin
                if (cleared_c) begin
                    state_d    = ST_IDLE;
                    adv_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else if (!legal_c) begin
                    state_d = ST_FAULT;
                    err_d   = ERR_ILLEGAL;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            state_d    = ST_ACQUIRE;
                            adv_cnt_d  = '0;
                            hold_cnt_d = '0;
                        end
                        ST_ACQUIRE: begin
                            // The advance that completes the lock already counts as a revolution.
                            if (adv_c) begin
                                if (adv_cnt_q + CNT_W'(1) == CNT_W'(LOCK_CNT)) begin
                                    state_d      = ST_LOCKED;
                                    adv_cnt_d    = '0;
                                    hold_cnt_d   = '0;
                                    count_wrap_c = wrap_c;
                                end else begin
                                    adv_cnt_d = adv_cnt_q + CNT_W'(1);
                                end
                            end else if (!hold_c) begin
                                adv_cnt_d = '0;
                            end
                        end
                        ST_LOCKED: begin
                            if (hold_c) begin
                                hold_cnt_d = hold_inc_c;
                                if (HOLD_MAX != 0 && hold_inc_c >= HOLD_W'(HOLD_MAX)) begin
                                    state_d = ST_FAULT;
                                    err_d   = ERR_STALL;
                                end
                            end else begin
                                hold_cnt_d = '0;
                                if (adv_c) begin
                                    count_wrap_c = wrap_c;
                                end else if (restart_c) begin
                                    state_d   = ST_ACQUIRE;
                                    adv_cnt_d = '0;
                                end else begin
                                    state_d = ST_FAULT;
                                    err_d   = ERR_SKIP;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end

            if (count_wrap_c && !(&wraps_q)) wraps_d = wraps_q + WRAP_W'(1);
        end

        locked_d = (state_d == ST_LOCKED);
        fault_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            prev_q     <= '0;
            idx_q      <= '0;
            adv_cnt_q  <= '0;
            hold_cnt_q <= '0;
            err_q      <= ERR_NONE;
            wraps_q    <= '0;
            locked_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            idx_q      <= idx_d;
            adv_cnt_q  <= adv_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            err_q      <= err_d;
            wraps_q    <= wraps_d;
            locked_q   <= locked_d;
            fault_q    <= fault_d;
        end
    end

    assign idx_o    = idx_q;
    assign locked_o = locked_q;
    assign fault_o  = fault_q;
    assign err_o    = err_q;
    assign wraps_o  = wraps_q;

endmodule

// File: rtl/ring_johnson_monitor.sv
// Hardware observer for the 4-bit ring/Johnson counter pair: one tracker per channel.
module ring_johnson_monitor
    import ring_johnson_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned WRAP_W     = 8,
    parameter int unsigned HOLD_MAX   = 0,
    parameter bit          SHIFT_LEFT = 1'b1
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  en,
    input  logic [SEQ_W-1:0]      qr,
    input  logic [SEQ_W-1:0]      qtr,
    input  logic                  err_clr,
    output logic [RING_IDX_W-1:0] ring_idx,
    output logic [JOHN_IDX_W-1:0] john_idx,
    output logic                  ring_locked,
    output logic                  john_locked,
    output logic                  ring_fault,
    output logic                  john_fault,
    output logic [1:0]            ring_err,
    output logic [1:0]            john_err,
    output logic [WRAP_W-1:0]     ring_wraps,
    output logic [WRAP_W-1:0]     john_wraps
);

    seq_track #(
        .MODE       (1'b0),
        .WIDTH      (SEQ_W),
        .IDX_W      (RING_IDX_W),
        .LOCK_CNT   (LOCK_CNT),
        .WRAP_W     (WRAP_W),
        .HOLD_MAX   (HOLD_MAX),
        .SHIFT_LEFT (SHIFT_LEFT)
    ) u_ring (
        .clk       (clk),
        .rst_n     (clr_n),
        .en_i      (en),
        .q_i       (qr),
        .err_clr_i (err_clr),
        .idx_o     (ring_idx),
        .locked_o  (ring_locked),
        .fault_o   (ring_fault),
        .err_o     (ring_err),
        .wraps_o   (ring_wraps)
    );

    seq_track #(
        .MODE       (1'b1),
        .WIDTH      (SEQ_W),
        .IDX_W      (JOHN_IDX_W),
        .LOCK_CNT   (LOCK_CNT),
        .WRAP_W     (WRAP_W),
        .HOLD_MAX   (HOLD_MAX),
        .SHIFT_LEFT (SHIFT_LEFT)
    ) u_john (
        .clk       (clk),
        .rst_n     (clr_n),
        .en_i      (en),
        .q_i       (qtr),
        .err_clr_i (err_clr),
        .idx_o     (john_idx),
        .locked_o  (john_locked),
        .fault_o   (john_fault),
        .err_o     (john_err),
        .wraps_o   (john_wraps)
    );

endmodule

// File: tb/tb_ring_johnson_monitor.sv
// Bench for ring_johnson_monitor: two instances (stall detection off / HOLD_MAX=3)
// driven in parallel and compared against a sequence-level reference model.
module tb_ring_johnson_monitor;

    localparam int S_IDLE = 0, S_ACQ = 1, S_LOCK = 2, S_FAULT = 3;
    localparam int LOCK = 4;
    localparam int WMAX = 255;

    logic       clk = 1'b0, clr_n = 1'b0, en = 1'b0, err_clr = 1'b0;
    logic [3:0] qr = 4'd0, qtr = 4'd0;

    logic [1:0] ring_idx_a, ring_idx_b, ring_err_a, ring_err_b, john_err_a, john_err_b;
    logic [2:0] john_idx_a, john_idx_b;
    logic       ring_locked_a, ring_locked_b, john_locked_a, john_locked_b;
    logic       ring_fault_a, ring_fault_b, john_fault_a, john_fault_b;
    logic [7:0] ring_wraps_a, ring_wraps_b, john_wraps_a, john_wraps_b;

    ring_johnson_monitor #(.LOCK_CNT(4), .WRAP_W(8), .HOLD_MAX(0), .SHIFT_LEFT(1'b1)) dut_a (
        .clk(clk), .clr_n(clr_n), .en(en), .qr(qr), .qtr(qtr), .err_clr(err_clr),
        .ring_idx(ring_idx_a), .john_idx(john_idx_a),
        .ring_locked(ring_locked_a), .john_locked(john_locked_a),
        .ring_fault(ring_fault_a), .john_fault(john_fault_a),
        .ring_err(ring_err_a), .john_err(john_err_a),
        .ring_wraps(ring_wraps_a), .john_wraps(john_wraps_a)
    );

    ring_johnson_monitor #(.LOCK_CNT(4), .WRAP_W(8), .HOLD_MAX(3), .SHIFT_LEFT(1'b1)) dut_b (
        .clk(clk), .clr_n(clr_n), .en(en), .qr(qr), .qtr(qtr), .err_clr(err_clr),
        .ring_idx(ring_idx_b), .john_idx(john_idx_b),
        .ring_locked(ring_locked_b), .john_locked(john_locked_b),
        .ring_fault(ring_fault_b), .john_fault(john_fault_b),
        .ring_err(ring_err_b), .john_err(john_err_b),
        .ring_wraps(ring_wraps_b), .john_wraps(john_wraps_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int idx;
        int prev;
        int adv;
        int hold;
        int err;
        int wraps;
    } ch_t;

    ch_t m [2][2];
    int  hmax     [2] = '{0, 3};
    int  ring_seq [4] = '{1, 2, 4, 8};
    int  john_seq [8] = '{0, 1, 3, 7, 15, 14, 12, 8};
    int  chk_cnt  = 0;
    int  pass_cnt = 0;

    function automatic int seq_at(int mode, int i);
        return mode ? john_seq[i] : ring_seq[i];
    endfunction

    function automatic int find(int mode, int v);
        int n;
        n = mode ? 8 : 4;
        for (int i = 0; i < n; i++) if (seq_at(mode, i) == v) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) m[d][c] = '{0, 0, 0, 0, 0, 0, 0};
    endtask

    // Reference behaviour of one channel on one enabled edge.
    task automatic mstep(input int d, input int mode, input int v, input bit ec);
        ch_t c;
        int  n, ci, pi;
        bit  is_hold, is_adv, wrap, cleared;
        c       = m[d][mode];
        n       = mode ? 8 : 4;
        ci      = find(mode, v);
        pi      = find(mode, c.prev);
        cleared = (mode == 0) && (v == 0);
        is_hold = (v == c.prev);
        is_adv  = !is_hold && (pi >= 0) && (ci == (pi + 1) % n);
        wrap    = is_adv && (pi == n - 1);
        if (ci >= 0) c.idx = ci;
        else if (cleared) c.idx = 0;
        if (ec && c.st == S_FAULT) begin
            c.st = S_IDLE; c.err = 0; c.adv = 0; c.hold = 0;
        end else if (c.st != S_FAULT) begin
            if (cleared) begin
                c.st = S_IDLE; c.adv = 0; c.hold = 0;
            end else if (ci < 0) begin
                c.st = S_FAULT; c.err = 1;
            end else if (c.st == S_IDLE) begin
                c.st = S_ACQ; c.adv = 0; c.hold = 0;
            end else if (c.st == S_ACQ) begin
                if (is_adv) begin
                    c.adv++;
                    if (c.adv == LOCK) begin
                        c.st = S_LOCK; c.adv = 0; c.hold = 0;
                        if (wrap && c.wraps < WMAX) c.wraps++;
                    end
                end else if (!is_hold) c.adv = 0;
            end else begin
                if (is_hold) begin
                    c.hold++;
                    if (hmax[d] > 0 && c.hold >= hmax[d]) begin c.st = S_FAULT; c.err = 3; end
                end else begin
                    c.hold = 0;
                    if (is_adv) begin
                        if (wrap && c.wraps < WMAX) c.wraps++;
                    end else if (ci == 0) begin
                        c.st = S_ACQ; c.adv = 0;
                    end else begin
                        c.st = S_FAULT; c.err = 2;
                    end
                end
            end
        end
        c.prev = v;
        m[d][mode] = c;
    endtask

    function automatic logic [28:0] exp_vec(int d);
        return {2'(m[d][0].idx), 3'(m[d][1].idx),
                m[d][0].st == S_LOCK, m[d][1].st == S_LOCK,
                m[d][0].st == S_FAULT, m[d][1].st == S_FAULT,
                2'(m[d][0].err), 2'(m[d][1].err),
                8'(m[d][0].wraps), 8'(m[d][1].wraps)};
    endfunction

    function automatic logic [28:0] obs_vec(int d);
        if (d == 0)
            return {ring_idx_a, john_idx_a, ring_locked_a, john_locked_a, ring_fault_a,
                    john_fault_a, ring_err_a, john_err_a, ring_wraps_a, john_wraps_a};
        return {ring_idx_b, john_idx_b, ring_locked_b, john_locked_b, ring_fault_b,
                john_fault_b, ring_err_b, john_err_b, ring_wraps_b, john_wraps_b};
    endfunction

    function automatic int gen(int mode, int pv);
        int n, pi, r, v;
        n  = mode ? 8 : 4;
        pi = find(mode, pv);
        r  = $urandom_range(0, 99);
        if (r < 65) return seq_at(mode, (pi < 0) ? 0 : (pi + 1) % n);
        if (r < 77) return pv;
        if (r < 83) return seq_at(mode, 0);
        if (r < 89) return seq_at(mode, $urandom_range(0, n - 1));
        if (r < 95) begin
            v = $urandom_range(1, 15);
            while (find(mode, v) >= 0) v = $urandom_range(1, 15);
            return v;
        end
        return 0;
    endfunction

    // One clock: drive inputs, let both DUTs and the model take the edge, sample 1ns later.
    task automatic tick(input bit e, input int r, input int j, input bit ec);
        en = e; qr = 4'(r); qtr = 4'(j); err_clr = ec;
        @(posedge clk);
        if (e) for (int d = 0; d < 2; d++) begin
            mstep(d, 0, r, ec);
            mstep(d, 1, j, ec);
        end
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0; en = 1'b0; qr = 4'd0; qtr = 4'd0; err_clr = 1'b0;
        model_reset();
        #2;
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; en = 1'b1; qr = 4'd1; qtr = 4'd3;
        model_reset();
        #3;
        for (int d = 0; d < 2; d++) begin
            chk_cnt++;
            if (obs_vec(d) !== 29'd0) $display("FAIL reset dut%0d got %h exp 0", d, obs_vec(d));
            else pass_cnt++;
        end
        do_reset();
    endtask

    task automatic test_ring_lock();
        int codes [5] = '{1, 2, 4, 8, 1};
        int idxs  [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, codes[i], 0, 1'b0);
            chk_cnt++;
            if (ring_idx_a !== 2'(idxs[i])) $display("FAIL ring_lock idx step%0d got %0d exp %0d", i, ring_idx_a, idxs[i]);
            else pass_cnt++;
            if (i == 3) begin
                chk_cnt++;
                if (ring_locked_a !== 1'b0) $display("FAIL ring_lock early got %b exp 0", ring_locked_a);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (ring_locked_a !== 1'b1) $display("FAIL ring_lock locked got %b exp 1", ring_locked_a);
        else pass_cnt++;
        chk_cnt++;
        if (ring_wraps_a !== 8'd1) $display("FAIL ring_lock wraps got %0d exp 1", ring_wraps_a);
        else pass_cnt++;
    endtask

    task automatic test_ring_clear();
        int codes [4] = '{2, 4, 8, 1};
        tick(1'b1, 0, 0, 1'b0);
        chk_cnt++;
        if ({ring_locked_a, ring_fault_a, ring_idx_a} !== 4'b0000)
            $display("FAIL ring_clear got l%b f%b i%0d exp l0 f0 i0", ring_locked_a, ring_fault_a, ring_idx_a);
        else pass_cnt++;
        tick(1'b1, 1, 0, 1'b0);
        chk_cnt++;
        if ({ring_locked_a, ring_fault_a} !== 2'b00) $display("FAIL ring_preset got l%b f%b exp l0 f0", ring_locked_a, ring_fault_a);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) tick(1'b1, codes[i], 0, 1'b0);
        chk_cnt++;
        if ({ring_locked_a, ring_wraps_a} !== {1'b1, 8'd2}) $display("FAIL ring_relock got l%b w%0d exp l1 w2", ring_locked_a, ring_wraps_a);
        else pass_cnt++;
    endtask

    task automatic test_john_illegal();
        int codes [5] = '{0, 1, 3, 7, 15};
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 0, codes[i], 1'b0);
        chk_cnt++;
        if ({john_locked_a, john_idx_a} !== {1'b1, 3'd4}) $display("FAIL john_lock got l%b i%0d exp l1 i4", john_locked_a, john_idx_a);
        else pass_cnt++;
        tick(1'b1, 0, 5, 1'b0);
        chk_cnt++;
        if ({john_fault_a, john_err_a, john_idx_a, john_locked_a} !== {1'b1, 2'd1, 3'd4, 1'b0})
            $display("FAIL john_illegal got f%b e%0d i%0d l%b exp f1 e1 i4 l0", john_fault_a, john_err_a, john_idx_a, john_locked_a);
        else pass_cnt++;
        tick(1'b1, 0, 15, 1'b1);
        chk_cnt++;
        if ({john_fault_a, john_err_a, john_locked_a} !== 4'b0000)
            $display("FAIL john_err_clr got f%b e%0d l%b exp f0 e0 l0", john_fault_a, john_err_a, john_locked_a);
        else pass_cnt++;
    endtask

    task automatic test_john_jump();
        int codes [11] = '{0, 1, 3, 7, 15, 14, 12, 8, 0, 1, 3};
        do_reset();
        for (int i = 0; i < 11; i++) tick(1'b1, 0, codes[i], 1'b0);
        chk_cnt++;
        if ({john_locked_a, john_wraps_a} !== {1'b1, 8'd1}) $display("FAIL john_wrap got l%b w%0d exp l1 w1", john_locked_a, john_wraps_a);
        else pass_cnt++;
        tick(1'b1, 0, 14, 1'b0);
        chk_cnt++;
        if ({john_fault_a, john_err_a} !== {1'b1, 2'd2}) $display("FAIL john_jump got f%b e%0d exp f1 e2", john_fault_a, john_err_a);
        else pass_cnt++;
        do_reset();
        for (int i = 0; i < 7; i++) tick(1'b1, 0, codes[i], 1'b0);
        tick(1'b1, 0, 0, 1'b0);
        chk_cnt++;
        if ({john_locked_a, john_fault_a, john_err_a, john_idx_a} !== 7'd0)
            $display("FAIL john_restart got l%b f%b e%0d i%0d exp all 0", john_locked_a, john_fault_a, john_err_a, john_idx_a);
        else pass_cnt++;
        for (int i = 1; i < 5; i++) tick(1'b1, 0, codes[i], 1'b0);
        chk_cnt++;
        if (john_locked_a !== 1'b1) $display("FAIL john_reacquire got %b exp 1", john_locked_a);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int codes [7] = '{1, 2, 4, 8, 1, 2, 4};
        do_reset();
        for (int i = 0; i < 7; i++) tick(1'b1, codes[i], 0, 1'b0);
        tick(1'b1, 4, 0, 1'b0);
        tick(1'b1, 4, 0, 1'b0);
        chk_cnt++;
        if (ring_fault_b !== 1'b0) $display("FAIL stall_early got %b exp 0", ring_fault_b);
        else pass_cnt++;
        tick(1'b1, 4, 0, 1'b0);
        chk_cnt++;
        if ({ring_fault_b, ring_err_b} !== {1'b1, 2'd3}) $display("FAIL stall_hold3 got f%b e%0d exp f1 e3", ring_fault_b, ring_err_b);
        else pass_cnt++;
        chk_cnt++;
        if ({ring_locked_a, ring_fault_a, ring_err_a} !== {1'b1, 1'b0, 2'd0})
            $display("FAIL stall_disabled got l%b f%b e%0d exp l1 f0 e0", ring_locked_a, ring_fault_a, ring_err_a);
        else pass_cnt++;
    endtask

    task automatic test_enable();
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            for (int d = 0; d < 2; d++) begin
                chk_cnt++;
                if (obs_vec(d) !== exp_vec(d)) $display("FAIL en_freeze dut%0d cyc%0d got %h exp %h", d, i, obs_vec(d), exp_vec(d));
                else pass_cnt++;
            end
        end
        tick(1'b1, 8, 1, 1'b1);
        for (int d = 0; d < 2; d++) begin
            chk_cnt++;
            if (obs_vec(d) !== exp_vec(d)) $display("FAIL en_resume dut%0d got %h exp %h", d, obs_vec(d), exp_vec(d));
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        int codes [6] = '{1, 2, 4, 8, 1, 2};
        int jc    [6] = '{0, 1, 3, 7, 15, 14};
        for (int i = 0; i < 6; i++) tick(1'b1, codes[i], jc[i], 1'b0);
        #2;
        clr_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk_cnt++;
            if (obs_vec(d) !== 29'd0) $display("FAIL async_reset dut%0d got %h exp 0", d, obs_vec(d));
            else pass_cnt++;
        end
        en = 1'b0; qr = 4'd0; qtr = 4'd0; err_clr = 1'b0;
        #1;
        clr_n = 1'b1;
    endtask

    task automatic test_random();
        int pr, pj, r, j;
        bit e, ec;
        do_reset();
        pr = 0; pj = 0;
        for (int i = 0; i < 700; i++) begin
            e  = ($urandom_range(0, 9) != 0);
            ec = ($urandom_range(0, 11) == 0);
            r  = gen(0, pr);
            j  = gen(1, pj);
            tick(e, r, j, ec);
            pr = r; pj = j;
            for (int d = 0; d < 2; d++) begin
                chk_cnt++;
                if (obs_vec(d) !== exp_vec(d)) $display("FAIL random dut%0d cyc%0d got %h exp %h", d, i, obs_vec(d), exp_vec(d));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int rev = 0; rev < 300; rev++)
            for (int k = 0; k < 4; k++) tick(1'b1, ring_seq[(k + 1) % 4], 0, 1'b0);
        chk_cnt++;
        if (ring_wraps_a !== 8'hFF) $display("FAIL wrap_saturate got %0d exp 255", ring_wraps_a);
        else pass_cnt++;
        chk_cnt++;
        if (obs_vec(0) !== exp_vec(0)) $display("FAIL wrap_saturate_all got %h exp %h", obs_vec(0), exp_vec(0));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_ring_lock();
        test_ring_clear();
        test_john_illegal();
        test_john_jump();
        test_stall();
        test_enable();
        test_async_reset();
        test_random();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ring_johnson_monitor.md
Name: ring_johnson_monitor

Overview:
- Downstream consumer of the 4-bit ring/Johnson counter pair. Samples both counter outputs every clock and decodes each into a state index.
- Checks legality and sequencing per channel, counts full revolutions, and raises sticky fault flags.
- Sits between the counter and the lab display/LED logic; gives verification a self-checking hardware observer.

Parameters:
- LOCK_CNT, 4, consecutive legal advances needed to go from ACQUIRE to LOCKED (1..15).
- WRAP_W, 8, width of each saturating revolution counter.
- HOLD_MAX, 0, consecutive hold cycles in LOCKED that raise a STALL fault; 0 disables stall detection.
- SHIFT_LEFT, 1, sequence direction. 1: ring 0001->0010->0100->1000; Johnson 0000->0001->0011->0111->1111->1110->1100->1000. 0: mirrored bit order for both.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- en  in  1  monitor enable; en=0 freezes all state, counters and outputs.
- qr  in  4  ring counter output.
- qtr  in  4  Johnson (twisted ring) counter output.
- err_clr  in  1  synchronous clear of both FAULT states.
- ring_idx  out  2  decoded ring index 0..3.
- john_idx  out  3  decoded Johnson index 0..7.
- ring_locked, john_locked  out  1 each  channel FSM is in LOCKED.
- ring_fault, john_fault  out  1 each  channel FSM is in FAULT (sticky).
- ring_err, john_err  out  2 each  fault cause: 00 none, 01 ILLEGAL, 10 SKIP, 11 STALL.
- ring_wraps  out  WRAP_W  saturating count of ring revolutions.
- john_wraps  out  WRAP_W  saturating count of Johnson revolutions.

Behaviour:
- Reset (clr_n=0, async): every output is 0, both FSMs go to IDLE, prev samples are 0, hold/advance counters are 0.
- Latency: each cycle with en=1, the live input is classified against prev (the sample from the last enabled edge). FSM, idx and counters update on that edge, so outputs reflect the pattern one edge after it is sampled. prev <= input on every enabled edge.
- Legality: ring is legal only if one-hot. Ring 0000 is CLEARED, not illegal. Johnson is legal only if it is one of the 8 sequence codes.
- Step classes: HOLD (input == prev), ADVANCE (input == successor of prev, including wrap from the last index to index 0), RESTART (input is index 0 but not the successor), JUMP (any other legal change).
- FSM states per channel: IDLE, ACQUIRE, LOCKED, FAULT.
- Priority per edge: err_clr > CLEARED > ILLEGAL > step class.
- err_clr=1: FAULT -> IDLE and err cleared. Any other state is unaffected. err_clr does not clear the wrap counters.
- Ring CLEARED (0000) in any non-FAULT state -> IDLE, idx=0.
- Illegal pattern in IDLE, ACQUIRE or LOCKED -> FAULT, err=01.
- IDLE: legal input -> ACQUIRE, adv_cnt=0.
- ACQUIRE:
  - ADVANCE increments adv_cnt; reaching LOCK_CNT -> LOCKED.
  - HOLD leaves adv_cnt unchanged.
  - RESTART or JUMP sets adv_cnt=0 and stays in ACQUIRE.
- LOCKED:
  - ADVANCE and HOLD stay in LOCKED.
  - RESTART -> ACQUIRE, adv_cnt=0 (a counter clr/preset is not a fault).
  - JUMP -> FAULT, err=10.
  - HOLD increments hold_cnt; any non-HOLD step zeroes it. If HOLD_MAX>0 and hold_cnt reaches HOLD_MAX -> FAULT, err=11.
- FAULT: holds; idx keeps tracking legal inputs; wrap counters freeze.
- Wraps: counted only in LOCKED, on an ADVANCE from the last index (ring 3, Johnson 7) to 0. Saturate at all-ones.
- idx shows the decoded index of the latest legal sample; it holds its value on an illegal sample.

Decomposition:
- Package ring_johnson_pkg:
  - FSM state enum (IDLE/ACQUIRE/LOCKED/FAULT).
  - err code constants.
  - Ring and Johnson sequence tables.
  - is_legal/next/index functions, parameterised by SHIFT_LEFT.
- One sub-module, seq_track: a single-channel tracker parameterised by MODE (0 ring, 1 Johnson), WIDTH and IDX_W. The top instantiates it twice; the top itself has no logic beyond wiring.

Test Plan:
- Reset then ring 0001->0010->0100->1000->0001 with en=1 -> ring_locked=1 one edge after the 4th advance. ring_wraps=1 after the 1000->0001 step. ring_idx tracks 0,1,2,3,0.
- Ring qr=0000 (counter clr) while LOCKED -> ring IDLE, ring_locked=0, ring_fault=0. Then qr=0001 (preset) -> ACQUIRE.
- Johnson 0000->0001->0011->0111->1111 -> john_locked=1. Force qtr=0101 -> john_fault=1, john_err=01. Assert err_clr one cycle -> fault=0, IDLE.
- LOCKED Johnson at 0011, drive 1110 (JUMP) -> john_err=10. Separately, from LOCKED at 1100 drive 0000 directly (RESTART) -> ACQUIRE, no fault.
- HOLD_MAX=3, ring LOCKED, qr held at 0100 for 3 enabled edges -> ring_err=11. With HOLD_MAX=0 the same stimulus gives no fault.
- en=0 for 5 cycles while the inputs change -> all outputs unchanged. clr_n pulsed mid-sequence -> all outputs 0 immediately, without waiting for clk.
